// File: rtl/booth_pp_accumulator_if.sv
// Bundle of the multiply handshake and the Booth encoder side-channel.
//   start, a, b        : multiply request and signed operands
//   busy, done, product: status and signed result
//   enc_b2/b1/b0       : multiplier triplet presented to the external encoder
//   enc_x/x2/comp      : encoder decode returned in the same cycle
// The slave modport is the accumulator core; the master modport is its user
// together with the encoder.
interface booth_pp_accumulator_if #(
    parameter int WIDTH = 16
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
    logic                   enc_b2;
    logic                   enc_b1;
    logic                   enc_b0;
    logic                   enc_x;
    logic                   enc_x2;
    logic                   enc_comp;

    modport slave (
        input  start, a, b, enc_x, enc_x2, enc_comp,
        output busy, done, product, enc_b2, enc_b1, enc_b0
    );

    modport master (
        output start, a, b, enc_x, enc_x2, enc_comp,
        input  busy, done, product, enc_b2, enc_b1, enc_b0
    );
endinterface

// File: rtl/booth_pp_accumulator.sv
// Sequential radix-4 Booth multiplier core (signed WIDTH x WIDTH).
// One Booth group per clock: the current multiplier triplet is driven out to
// an external encoder, its X / X_2 / Comp decode comes straight back, and the
// resulting partial product is shifted into place and added to a 2*WIDTH
// accumulator. A multiply takes NGRP RUN cycles followed by one FIN cycle in
// which done pulses; start in FIN chains the next multiply without a gap.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of booth_pp_accumulator_if (start/a/b in,
//                busy/done/product out, encoder triplet out, decode in)
module booth_pp_accumulator #(
    parameter int WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    booth_pp_accumulator_if.slave       bus
);

    localparam int NGRP = WIDTH / 2;
    localparam int IDXW = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int BPW  = $clog2(WIDTH + 1);
    localparam int PPW  = WIDTH + 2;
    localparam int PW   = 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               load_s;
    logic               step_s;
    logic               last_s;

    logic [WIDTH-1:0]   a_r;
    logic [WIDTH:0]     b_ext_r;
    logic [PW-1:0]      acc_r;
    logic [IDXW-1:0]    idx_r;
    logic               busy_r;
    logic               done_r;
    logic [PW-1:0]      product_r;

    logic [BPW-1:0]     bitpos_s;
    logic [2:0]         trip_s;
    logic [PPW-1:0]     m_s;
    logic [PPW-1:0]     pp_s;
    logic [PW-1:0]      pp_ext_s;
    logic [PW-1:0]      acc_next_s;

    // Next-state decode: when to capture operands and when to accumulate.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        step_s  = 1'b0;
        last_s  = (idx_r == IDXW'(NGRP - 1));
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_RUN;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FIN: begin
                if (bus.start) begin
                    state_s = ST_RUN;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Triplet for group idx is b_ext[2*idx+2 : 2*idx]; b_ext carries the
    // implicit zero below the LSB so group 0 sees {b[1], b[0], 0}.
    always_comb begin
        bitpos_s = BPW'({idx_r, 1'b0});
        if (state_r == ST_RUN) begin
            trip_s = b_ext_r[bitpos_s +: 3];
        end else begin
            trip_s = 3'b000;
        end
    end

    assign bus.enc_b2 = trip_s[2];
    assign bus.enc_b1 = trip_s[1];
    assign bus.enc_b0 = trip_s[0];

    // Partial product from the encoder decode. Two guard bits are needed so
    // that 2*(-2^(WIDTH-1)) and its negation are both representable.
    always_comb begin
        if (bus.enc_x) begin
            m_s = {{2{a_r[WIDTH-1]}}, a_r};
        end else if (bus.enc_x2) begin
            m_s = {a_r[WIDTH-1], a_r, 1'b0};
        end else begin
            m_s = {PPW{1'b0}};
        end

        if (bus.enc_comp) begin
            pp_s = ~m_s + {{(PPW-1){1'b0}}, 1'b1};
        end else begin
            pp_s = m_s;
        end

        pp_ext_s   = {{(PW-PPW){pp_s[PPW-1]}}, pp_s};
        acc_next_s = acc_r + (pp_ext_s << {idx_r, 1'b0});
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, group index and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_ext_r <= {(WIDTH+1){1'b0}};
            acc_r   <= {PW{1'b0}};
            idx_r   <= {IDXW{1'b0}};
        end else if (load_s) begin
            a_r     <= bus.a;
            b_ext_r <= {bus.b, 1'b0};
            acc_r   <= {PW{1'b0}};
            idx_r   <= {IDXW{1'b0}};
        end else if (step_s) begin
            acc_r   <= acc_next_s;
            idx_r   <= idx_r + {{(IDXW-1){1'b0}}, 1'b1};
        end
    end

    // Registered status and result; product only moves on the final group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= {PW{1'b0}};
        end else begin
            busy_r <= (state_s == ST_RUN);
            done_r <= (state_s == ST_FIN);
            if (step_s && last_s) begin
                product_r <= acc_next_s;
            end
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Self-checking bench for booth_pp_accumulator: directed vector table,
// hand-written handshake corner sequences and randomized signed operands
// compared with a plain signed multiplication.
module tb_booth_pp_accumulator;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] last_exp;

    booth_pp_accumulator_if #(.WIDTH(16)) bus ();

    booth_pp_accumulator #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encoder model: the triplet names a Booth digit -2..+2.
    function automatic logic [2:0] enc_model(input logic [2:0] t);
        int d;
        d = -2 * int'(t[2]) + int'(t[1]) + int'(t[0]);
        return {(d == 1 || d == -1), (d == 2 || d == -2), (d < 0)};
    endfunction

    logic [2:0] enc_s;
    assign enc_s        = enc_model({bus.enc_b2, bus.enc_b1, bus.enc_b0});
    assign bus.enc_x    = enc_s[2];
    assign bus.enc_x2   = enc_s[1];
    assign bus.enc_comp = enc_s[0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] trip_now();
        return {bus.enc_b2, bus.enc_b1, bus.enc_b0};
    endfunction

    // One multiply with a start pulse; checks latency, busy length, triplets,
    // result hold during RUN, the result and the single-cycle done.
    task automatic run_mul(input logic [15:0] ta, input logic [15:0] tbv,
                           input logic [31:0] exp, input string name);
        int lat;
        int busy_cnt;
        bit seen;
        logic [16:0] bext;
        bext = {tbv, 1'b0};
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tbv;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        lat = 1;
        busy_cnt = 0;
        seen = 1'b0;
        while (!seen && lat <= 20) begin
            if (bus.busy) begin
                check({name, "_trip"}, 32'(trip_now()), 32'(bext[2*busy_cnt +: 3]));
                busy_cnt++;
                if (busy_cnt == 4) check({name, "_hold"}, bus.product, last_exp);
            end
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_latency"}, 32'(lat), 32'd9);
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({name, "_fin_trip"}, 32'(trip_now()), 32'd0);
        check({name, "_prod"}, bus.product, exp);
        last_exp = exp;
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        string       name;
    } vec_t;

    vec_t vecs[10];
    logic [15:0] corners[5];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int dones;
        logic signed [15:0] ra;
        logic signed [15:0] rb;
        logic signed [31:0] re;

        vecs[0] = '{16'd3,      16'd5,      32'h0000000F, "v_3x5"};
        vecs[1] = '{16'hFFFF,   16'hFFFF,   32'h00000001, "v_m1xm1"};
        vecs[2] = '{16'h8000,   16'h8000,   32'h40000000, "v_minxmin"};
        vecs[3] = '{16'h7FFF,   16'h8000,   32'hC0008000, "v_maxxmin"};
        vecs[4] = '{16'h8000,   16'h7FFF,   32'hC0008000, "v_minxmax"};
        vecs[5] = '{16'h7FFF,   16'h7FFF,   32'h3FFF0001, "v_maxxmax"};
        vecs[6] = '{16'd7,      16'hFFFD,   32'hFFFFFFEB, "v_7xm3"};
        vecs[7] = '{16'hFFFE,   16'd100,    32'hFFFFFF38, "v_m2x100"};
        vecs[8] = '{16'h0000,   16'h8000,   32'h00000000, "v_0xmin"};
        vecs[9] = '{16'd12,     16'd12,     32'h00000090, "v_12x12"};
        corners = '{16'h8000, 16'h8001, 16'h7FFF, 16'h0000, 16'hFFFF};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = 16'd0;
        bus.b     = 16'd0;
        last_exp  = 32'd0;
        #3;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_product", bus.product, 32'd0);
        check("rst_trip", 32'(trip_now()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_mul(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].name);
        end

        // Back-to-back: start held through FIN chains the second multiply.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 16'd7;
        bus.b = 16'hFFFD;
        for (int n = 1; n <= 18; n++) begin
            @(negedge clk);
            if (n == 9) begin
                check("b2b_done1", 32'(bus.done), 32'd1);
                check("b2b_busy_fin", 32'(bus.busy), 32'd0);
                check("b2b_prod1", bus.product, 32'hFFFFFFEB);
                bus.a = 16'hFFFE;
                bus.b = 16'd100;
            end else if (n == 18) begin
                check("b2b_done2", 32'(bus.done), 32'd1);
                check("b2b_prod2", bus.product, 32'hFFFFFF38);
                bus.start = 1'b0;
            end else begin
                check("b2b_busy_run", 32'(bus.busy), 32'd1);
                check("b2b_done_run", 32'(bus.done), 32'd0);
            end
        end
        @(negedge clk);
        check("b2b_idle_done", 32'(bus.done), 32'd0);
        check("b2b_idle_busy", 32'(bus.busy), 32'd0);
        last_exp = 32'hFFFFFF38;

        // start during RUN is ignored; operands are not re-captured.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 16'd100;
        bus.b = 16'd200;
        dones = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            bus.start = (n == 4);
            if (n == 4) begin
                bus.a = 16'hFFFB;
                bus.b = 16'd9;
            end
            if (bus.done) dones++;
            if (n == 9) check("ign_prod", bus.product, 32'h00004E20);
        end
        check("ign_done_count", 32'(dones), 32'd1);
        check("ign_idle_busy", 32'(bus.busy), 32'd0);
        last_exp = 32'h00004E20;

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 16'd1000;
        bus.b = 16'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_done", 32'(bus.done), 32'd0);
        check("mrst_product", bus.product, 32'd0);
        check("mrst_trip", 32'(trip_now()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_exp = 32'd0;
        run_mul(16'd12, 16'd12, 32'h00000090, "mrst_12x12");

        // Randomized operands against plain signed multiplication.
        for (int k = 0; k < 2500; k++) begin
            ra = ($urandom_range(3) == 0) ? corners[$urandom_range(4)] : 16'($urandom);
            rb = ($urandom_range(3) == 0) ? corners[$urandom_range(4)] : 16'($urandom);
            re = ra * rb;
            run_mul(ra, rb, re, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
